// File: rtl/pwm_pkg.sv
`timescale 1ns/1ps
// pwm_pkg
// Shared constants, types and helpers for the PWM stimulus generator.
//   COUNT_W         width of the period, high-time and counter values
//   CLK_HZ          frequency of MAX10_CLK1_50
//   DEFAULT_*       power-up waveform: 1 kHz at 50 % duty
//   pwm_state_e     run-control state of the generator
//   hz_to_period()  converts a frequency in Hz into a period in clock cycles
package pwm_pkg;

  localparam int          COUNT_W         = 27;
  localparam int unsigned CLK_HZ          = 50_000_000;
  localparam int unsigned DEFAULT_FREQ_HZ = 1000;
  localparam int unsigned DEFAULT_PERIOD  = CLK_HZ / DEFAULT_FREQ_HZ;
  localparam int unsigned DEFAULT_HIGH    = DEFAULT_PERIOD / 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_e;

  // A zero frequency has no meaningful period; return 0, which the
  // generator treats as a degenerate (silent) setting.
  function automatic int unsigned hz_to_period(input int unsigned f);
    return (f == 32'd0) ? 32'd0 : CLK_HZ / f;
  endfunction

endpackage

// File: rtl/pwm_cfg_buffer.sv
`timescale 1ns/1ps
// pwm_cfg_buffer
// Double buffer for the PWM settings. A load strobe captures the requested
// period/high time into the pending registers; the generator's period
// boundary copies them into the active registers, so a new setting never
// cuts a period short.
//   clk, reset              clock and asynchronous active-high reset
//   load                    capture period_in/high_in as pending
//   period_in, high_in      requested settings
//   boundary                generator is starting a new period this cycle
//   act_period, act_high    settings in force for the current period
//   cfg_pending             pending settings not yet applied
module pwm_cfg_buffer
  import pwm_pkg::*;
#(
  parameter int          COUNT_W      = pwm_pkg::COUNT_W,
  parameter int unsigned RESET_PERIOD = DEFAULT_PERIOD,
  parameter int unsigned RESET_HIGH   = DEFAULT_HIGH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [COUNT_W-1:0] period_in,
  input  logic [COUNT_W-1:0] high_in,
  input  logic               boundary,
  output logic [COUNT_W-1:0] act_period,
  output logic [COUNT_W-1:0] act_high,
  output logic               cfg_pending
);

  logic [COUNT_W-1:0] pend_period;
  logic [COUNT_W-1:0] pend_high;
  logic               pend_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_period  <= COUNT_W'(RESET_PERIOD);
      act_high    <= COUNT_W'(RESET_HIGH);
      pend_period <= '0;
      pend_high   <= '0;
      pend_valid  <= 1'b0;
    end else begin
      // The boundary always consumes what was pending before this edge.
      if (boundary && pend_valid) begin
        act_period <= pend_period;
        act_high   <= pend_high;
      end
      // A load in the same cycle as a boundary wins over the clear, so the
      // fresh values wait for the following boundary.
      if (load) begin
        pend_period <= period_in;
        pend_high   <= high_in;
        pend_valid  <= 1'b1;
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign cfg_pending = pend_valid;

endmodule

// File: rtl/pwm_generator.sv
`timescale 1ns/1ps
// pwm_generator
// Rectangular-wave generator with programmable period and high time,
// counted in MAX10_CLK1_50 cycles. Settings are double-buffered in
// pwm_cfg_buffer and switch only at a period boundary.
//   MAX10_CLK1_50         50 MHz system clock
//   reset                 asynchronous active-high reset
//   enable                run control; 0 forces idle and abandons the period
//   load                  one-cycle strobe capturing period_in/high_in
//   period_in, high_in    requested period and high time in clock cycles
//   pwm_out               generated waveform (registered)
//   period_start          one-cycle pulse on the first cycle of each period
//   cfg_pending           pending settings not yet applied
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int          COUNT_W      = pwm_pkg::COUNT_W,
  parameter int unsigned RESET_PERIOD = hz_to_period(DEFAULT_FREQ_HZ),
  parameter int unsigned RESET_HIGH   = DEFAULT_HIGH
) (
  input  logic               MAX10_CLK1_50,
  input  logic               reset,
  input  logic               enable,
  input  logic               load,
  input  logic [COUNT_W-1:0] period_in,
  input  logic [COUNT_W-1:0] high_in,
  output logic               pwm_out,
  output logic               period_start,
  output logic               cfg_pending
);

  pwm_state_e         state;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] act_period;
  logic [COUNT_W-1:0] act_high;
  logic               run_now;
  logic               short_period;
  logic               boundary;

  // Dropping enable takes effect in the same cycle, so RUN alone is not
  // enough to count as running.
  assign run_now = (state == RUN) && enable;

  // Periods of 0 or 1 cannot hold a visible pulse: every running cycle is a
  // boundary and the outputs stay low.
  assign short_period = (act_period <= COUNT_W'(1));

  assign boundary = (run_now && (short_period || (cnt == act_period - COUNT_W'(1))))
                  || ((state == IDLE) && enable);

  pwm_cfg_buffer #(
    .COUNT_W      (COUNT_W),
    .RESET_PERIOD (RESET_PERIOD),
    .RESET_HIGH   (RESET_HIGH)
  ) u_cfg_buffer (
    .clk         (MAX10_CLK1_50),
    .reset       (reset),
    .load        (load),
    .period_in   (period_in),
    .high_in     (high_in),
    .boundary    (boundary),
    .act_period  (act_period),
    .act_high    (act_high),
    .cfg_pending (cfg_pending)
  );

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state <= enable ? RUN : IDLE;

      // cnt stays at 0 while idle, so the IDLE->RUN boundary starts cleanly.
      if (boundary || !run_now) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + COUNT_W'(1);
      end

      // Outputs lag cnt by one cycle; act_high >= act_period naturally
      // gives a constant high because cnt never reaches act_period.
      pwm_out      <= run_now && !short_period && (cnt < act_high);
      period_start <= run_now && !short_period && (cnt == '0);
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
`timescale 1ns/1ps
module tb_pwm_generator;
  import pwm_pkg::*;

  localparam int W = COUNT_W;

  logic         MAX10_CLK1_50 = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] period_in = '0;
  logic [W-1:0] high_in = '0;
  logic         pwm_out;
  logic         period_start;
  logic         cfg_pending;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: each new period is expanded into a queue of
  // {pwm, period_start} samples that running cycles consume one by one.
  bit [1:0]    pat_q[$];
  bit          m_run, m_pend, exp_pwm, exp_ps;
  int unsigned m_per, m_hi, m_pend_per, m_pend_hi;

  always #10 MAX10_CLK1_50 = ~MAX10_CLK1_50;

  pwm_generator dut (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .reset         (reset),
    .enable        (enable),
    .load          (load),
    .period_in     (period_in),
    .high_in       (high_in),
    .pwm_out       (pwm_out),
    .period_start  (period_start),
    .cfg_pending   (cfg_pending)
  );

  function automatic int unsigned rnd27();
    return $urandom & 32'h07FF_FFFF;
  endfunction

  task automatic model_reset();
    pat_q.delete();
    m_run = 1'b0; m_pend = 1'b0;
    m_per = 50000; m_hi = 25000;
    m_pend_per = 0; m_pend_hi = 0;
    exp_pwm = 1'b0; exp_ps = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit ld, input int unsigned p, input int unsigned h);
    bit       start;
    bit [1:0] e;
    start = 1'b0; exp_pwm = 1'b0; exp_ps = 1'b0;
    if (m_run && en) begin
      if (pat_q.size() > 0) begin
        e = pat_q.pop_front();
        exp_pwm = e[1]; exp_ps = e[0];
      end
      start = (pat_q.size() == 0);
    end else begin
      pat_q.delete();
      start = !m_run && en;
    end
    if (start) begin
      if (m_pend) begin
        m_per = m_pend_per; m_hi = m_pend_hi; m_pend = 1'b0;
      end
      if (m_per > 1)
        for (int unsigned i = 0; i < m_per; i++) pat_q.push_back({i < m_hi, i == 0});
    end
    if (ld) begin
      m_pend_per = p; m_pend_hi = h; m_pend = 1'b1;
    end
    m_run = en;
  endtask

  // Counter value before the next edge, as the model sees it.
  function automatic int unsigned model_cnt();
    return m_per - pat_q.size();
  endfunction

  task automatic step(input bit en, input bit ld, input int unsigned p, input int unsigned h);
    enable = en; load = ld; period_in = W'(p); high_in = W'(h);
    @(posedge MAX10_CLK1_50);
    if (reset) model_reset(); else model_edge(en, ld, p, h);
    cyc++;
    #1;
    n_vec++;
    if (pwm_out !== exp_pwm) begin
      n_err++; $display("FAIL pwm_out cyc=%0d: got %b, want %b", cyc, pwm_out, exp_pwm);
    end
    n_vec++;
    if (period_start !== exp_ps) begin
      n_err++; $display("FAIL period_start cyc=%0d: got %b, want %b", cyc, period_start, exp_ps);
    end
    n_vec++;
    if (cfg_pending !== m_pend) begin
      n_err++; $display("FAIL cfg_pending cyc=%0d: got %b, want %b", cyc, cfg_pending, m_pend);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    step(0, 1, 10, 3);
    step(1, 0, rnd27(), rnd27());
    n_vec++;
    if (pwm_out !== 1'b0 || period_start !== 1'b0 || cfg_pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got pwm=%b ps=%b pend=%b, want 0 0 0", pwm_out, period_start, cfg_pending);
    end
    reset = 1'b0;
    step(0, 0, rnd27(), rnd27());
    step(0, 0, rnd27(), rnd27());
    $display("test_reset done, cyc=%0d", cyc);
  endtask

  // Default 1 kHz / 50 % waveform, with a 10/3 load landing mid-period.
  task automatic test_default_and_mid_load();
    int highs = 0, ps_first = -1, ps_second = -1, ps_late = 0;
    int load_at = 30000 + int'($urandom_range(0, 9000));
    for (int c = 0; c <= 50040; c++) begin
      if (c == load_at) step(1, 1, 10, 3);
      else step(1, 0, rnd27(), rnd27());
      if (c >= 1 && c <= 50000 && pwm_out === 1'b1) highs++;
      if (period_start === 1'b1) begin
        if (ps_first < 0) ps_first = c;
        else if (ps_second < 0) ps_second = c;
        else ps_late++;
      end
      if (c == 49999) begin
        n_vec++;
        if (cfg_pending !== 1'b1) begin
          n_err++; $display("FAIL pending_before_switch: got %b, want 1", cfg_pending);
        end
      end
      if (c == 50000) begin
        n_vec++;
        if (cfg_pending !== 1'b0) begin
          n_err++; $display("FAIL pending_after_switch: got %b, want 0", cfg_pending);
        end
      end
    end
    n_vec++;
    if (highs != 25000) begin
      n_err++; $display("FAIL default_high_cycles: got %0d, want 25000", highs);
    end
    n_vec++;
    if (ps_first != 1 || ps_second != 50001) begin
      n_err++; $display("FAIL default_period_start: got %0d,%0d, want 1,50001", ps_first, ps_second);
    end
    n_vec++;
    if (ps_late != 3) begin
      n_err++; $display("FAIL short_period_pulses: got %0d, want 3", ps_late);
    end
    $display("test_default_and_mid_load done, load at %0d, highs=%0d", load_at, highs);
  endtask

  task automatic test_load_at_boundary();
    int guard = 0;
    int b;
    while (!(m_run && pat_q.size() == 1) && guard < 50) begin
      step(1, 0, rnd27(), rnd27());
      guard++;
    end
    n_vec++;
    if (guard >= 50) begin
      n_err++; $display("FAIL boundary_wait: got timeout after %0d cycles, want boundary", guard);
    end
    step(1, 1, 7, 5);
    b = cyc;
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, rnd27(), rnd27());
      if (cyc == b + 9) begin
        n_vec++;
        if (cfg_pending !== 1'b1) begin
          n_err++; $display("FAIL coincident_pending_held: got %b, want 1", cfg_pending);
        end
      end
      if (cyc == b + 10) begin
        n_vec++;
        if (cfg_pending !== 1'b0) begin
          n_err++; $display("FAIL coincident_pending_cleared: got %b, want 0", cfg_pending);
        end
      end
      if (cyc == b + 11 || cyc == b + 18) begin
        n_vec++;
        if (period_start !== 1'b1) begin
          n_err++; $display("FAIL coincident_period_start cyc=%0d: got %b, want 1", cyc, period_start);
        end
      end
    end
    $display("test_load_at_boundary done, boundary at cyc=%0d", b);
  endtask

  task automatic test_degenerate_high();
    int unsigned hi_set[2] = '{0, 12};
    int          want_hi[2] = '{0, 20};
    for (int t = 0; t < 2; t++) begin
      int highs = 0, pss = 0;
      step(1, 1, 10, hi_set[t]);
      for (int c = 0; c < 35; c++) begin
        step(1, 0, rnd27(), rnd27());
        if (c >= 15) begin
          if (pwm_out === 1'b1) highs++;
          if (period_start === 1'b1) pss++;
        end
      end
      n_vec++;
      if (highs != want_hi[t] || pss != 2) begin
        n_err++;
        $display("FAIL degenerate_high h=%0d: got highs=%0d ps=%0d, want %0d and 2", hi_set[t], highs, pss, want_hi[t]);
      end
      $display("test_degenerate_high h=%0d: highs=%0d ps=%0d", hi_set[t], highs, pss);
    end
  endtask

  task automatic test_degenerate_period();
    int unsigned per_set[2] = '{1, 0};
    for (int t = 0; t < 2; t++) begin
      int act = 0;
      step(1, 1, per_set[t], $urandom_range(0, 20));
      for (int c = 0; c < 30; c++) begin
        step(1, 0, rnd27(), rnd27());
        if (c >= 15 && (pwm_out === 1'b1 || period_start === 1'b1)) act++;
      end
      n_vec++;
      if (act != 0) begin
        n_err++; $display("FAIL degenerate_period p=%0d: got %0d active cycles, want 0", per_set[t], act);
      end
      $display("test_degenerate_period p=%0d: active=%0d", per_set[t], act);
    end
  endtask

  task automatic test_enable_drop();
    int guard = 0;
    step(1, 1, 10, 6);
    repeat (20) step(1, 0, rnd27(), rnd27());
    while (model_cnt() != 2 && guard < 30) begin
      step(1, 0, rnd27(), rnd27());
      guard++;
    end
    n_vec++;
    if (pwm_out !== 1'b1) begin
      n_err++; $display("FAIL pwm_before_drop: got %b, want 1", pwm_out);
    end
    step(0, 0, rnd27(), rnd27());
    n_vec++;
    if (pwm_out !== 1'b0 || period_start !== 1'b0) begin
      n_err++; $display("FAIL enable_drop: got pwm=%b ps=%b, want 0 0", pwm_out, period_start);
    end
    repeat (3) step(0, 0, rnd27(), rnd27());
    repeat (15) step(1, 0, rnd27(), rnd27());
    $display("test_enable_drop done, cyc=%0d", cyc);
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (model_cnt() != 3 && guard < 30) begin
      step(1, 0, rnd27(), rnd27());
      guard++;
    end
    step(1, 1, 9, 4);
    n_vec++;
    if (pwm_out !== 1'b1 || cfg_pending !== 1'b1) begin
      n_err++; $display("FAIL before_reset: got pwm=%b pend=%b, want 1 1", pwm_out, cfg_pending);
    end
    #3 reset = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (pwm_out !== 1'b0 || period_start !== 1'b0 || cfg_pending !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got pwm=%b ps=%b pend=%b, want 0 0 0", pwm_out, period_start, cfg_pending);
    end
    step(1, 0, rnd27(), rnd27());
    step(1, 0, rnd27(), rnd27());
    reset = 1'b0;
    step(0, 0, rnd27(), rnd27());
    // A surviving 9/4 setting would drop pwm_out after four cycles here.
    repeat (12) step(1, 0, rnd27(), rnd27());
    n_vec++;
    if (pwm_out !== 1'b1) begin
      n_err++; $display("FAIL default_after_reset: got %b, want 1", pwm_out);
    end
    $display("test_reset_mid done, cyc=%0d", cyc);
  endtask

  task automatic test_random();
    step(0, 0, rnd27(), rnd27());
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 20), $urandom_range(0, 22));
    end
    $display("test_random done, cyc=%0d", cyc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish by %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_default_and_mid_load();
    test_load_at_boundary();
    test_degenerate_high();
    test_degenerate_period();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
